pipe_mem_stage_p: RTL and testbench

Parametrised successor of the MEM pipeline stage. It contains the EX/MEM pipeline register with stall/flush control and a word-organised data memory. The memory supports byte, half and word stores with byte lanes, plus sign- or zero-extending loads. It sits between the EX stage and the MEM/WB register of the 5-stage core, and drives the MEM-side forwarding/writeback signals.

---
 rtl/pipe_mem_stage_p.sv | 149 ++++++++++++++
 tb/tb_pipe_mem_stage_p.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage_p.sv
// EX/MEM pipeline register plus byte-lane data memory for the MEM stage.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module pipe_mem_stage_p #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              stall,
    input  logic              flush,
    input  logic              EXwreg,
    input  logic              EXm2reg,
    input  logic              EXwmem,
    input  logic [1:0]        EXsize,
    input  logic              EXsext,
    input  logic [4:0]        EXwn,
    input  logic [DATA_W-1:0] EXaluResult,
    input  logic [DATA_W-1:0] EXdi,
    output logic              MEMwreg,
    output logic              MEMm2reg,
    output logic [4:0]        MEMwn,
    output logic [DATA_W-1:0] MEMaluResult,
    output logic [DATA_W-1:0] MEMmemOut,
    output logic              MEMmisalign
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);

    logic              wreg_q,  wreg_d;
    logic              m2reg_q, m2reg_d;
    logic              wmem_q,  wmem_d;
    logic [1:0]        size_q,  size_d;
    logic              sext_q,  sext_d;
    logic [4:0]        wn_q,    wn_d;
    logic [DATA_W-1:0] alu_q,   alu_d;
    logic [DATA_W-1:0] di_q,    di_d;

    always_comb begin
        wreg_d  = wreg_q;
        m2reg_d = m2reg_q;
        wmem_d  = wmem_q;
        size_d  = size_q;
        sext_d  = sext_q;
        wn_d    = wn_q;
        alu_d   = alu_q;
        di_d    = di_q;
        if (flush || !stall) begin
            wreg_d  = EXwreg;
            m2reg_d = EXm2reg;
            wmem_d  = EXwmem;
            size_d  = EXsize;
            sext_d  = EXsext;
            wn_d    = EXwn;
            alu_d   = EXaluResult;
            di_d    = EXdi;
        end
        // A flush turns the slot into a bubble with no side effects.
        if (flush) begin
            wreg_d  = 1'b0;
            m2reg_d = 1'b0;
            wmem_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            wn_q    <= 5'd0;
            alu_q   <= '0;
            di_q    <= '0;
        end else begin
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            wmem_q  <= wmem_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            wn_q    <= wn_d;
            alu_q   <= alu_d;
            di_q    <= di_d;
        end
    end

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] idx;
    logic [LANE_W-1:0] off;
    logic [LANE_W+2:0] sh;
    logic [1:0]        size_eff;
    logic [3:0]        nbytes;
    logic [6:0]        nbits;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] ld;
    logic              sign;
    logic              trap;
    logic              we;

    always_comb begin
        idx      = alu_q[ADDR_W+LANE_W-1:LANE_W];
        off      = alu_q[LANE_W-1:0];
        sh       = {off, 3'b000};
        size_eff = size_q;
        if (DATA_W == 32 && size_q == 2'b11) size_eff = 2'b10;
        nbytes   = 4'd1 << size_eff;
        nbits    = {nbytes, 3'b000};
        // Shifting lanes past the word top drops crossing bytes.
        be       = ~({NB{1'b1}} << nbytes) << off;
        wdata    = di_q << sh;
        rd_sh    = mem[idx] >> sh;
        keep     = ~({DATA_W{1'b1}} << nbits);
        sign     = |(rd_sh & (keep ^ (keep >> 1)));
        ld       = (rd_sh & keep) | ((sext_q && sign) ? ~keep : '0);
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic [LANE_W-1:0] lane_lo;
    logic              misal;
    assign lane_lo = LANE_W'(nbytes - 4'd1);
    assign misal   = (off & lane_lo) != '0;
    assign trap    = misal & (wmem_q | m2reg_q);
`else
    assign trap    = 1'b0;
`endif

    assign we = wmem_q & ~stall & ~clr & ~trap;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign MEMwreg      = wreg_q;
    assign MEMm2reg     = m2reg_q;
    assign MEMwn        = wn_q;
    assign MEMaluResult = alu_q;
    assign MEMmemOut    = trap ? '0 : ld;
    assign MEMmisalign  = trap;

endmodule

// File: tb/tb_pipe_mem_stage_p.sv
// Directed bench for pipe_mem_stage_p at DATA_W=32, ADDR_W=10.
// Expectations are hand-computed constants.
module tb_pipe_mem_stage_p;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        EXwreg = 1'b0;
    logic        EXm2reg = 1'b0;
    logic        EXwmem = 1'b0;
    logic [1:0]  EXsize = 2'b00;
    logic        EXsext = 1'b0;
    logic [4:0]  EXwn = 5'd0;
    logic [31:0] EXaluResult = 32'd0;
    logic [31:0] EXdi = 32'd0;
    logic        MEMwreg;
    logic        MEMm2reg;
    logic [4:0]  MEMwn;
    logic [31:0] MEMaluResult;
    logic [31:0] MEMmemOut;
    logic        MEMmisalign;

    int errors = 0;
    int checks = 0;

    pipe_mem_stage_p #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk(clk),
        .clr(clr),
        .stall(stall),
        .flush(flush),
        .EXwreg(EXwreg),
        .EXm2reg(EXm2reg),
        .EXwmem(EXwmem),
        .EXsize(EXsize),
        .EXsext(EXsext),
        .EXwn(EXwn),
        .EXaluResult(EXaluResult),
        .EXdi(EXdi),
        .MEMwreg(MEMwreg),
        .MEMm2reg(MEMm2reg),
        .MEMwn(MEMwn),
        .MEMaluResult(MEMaluResult),
        .MEMmemOut(MEMmemOut),
        .MEMmisalign(MEMmisalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic wr, input logic m2, input logic wm,
                      input logic [1:0] sz, input logic sx, input logic [4:0] wn,
                      input logic [31:0] alu, input logic [31:0] di);
        EXwreg = wr;
        EXm2reg = m2;
        EXwmem = wm;
        EXsize = sz;
        EXsext = sx;
        EXwn = wn;
        EXaluResult = alu;
        EXdi = di;
    endtask

    initial begin
        // reset with busy EX inputs
        ex(1, 1, 1, 2'b10, 1, 5'd7, 32'h55, 32'hFFFF_FFFF);
        tick();
        tick();
        chk("rst_wreg", {31'd0, MEMwreg}, 32'd0);
        chk("rst_m2reg", {31'd0, MEMm2reg}, 32'd0);
        chk("rst_wn", {27'd0, MEMwn}, 32'd0);
        chk("rst_alu", MEMaluResult, 32'd0);
        chk("rst_mis", {31'd0, MEMmisalign}, 32'd0);
        clr = 1'b0;
        ex(1, 0, 0, 2'b10, 0, 5'd5, 32'h10, 32'h0);
        tick();
        chk("cap_wn", {27'd0, MEMwn}, 32'd5);
        chk("cap_alu", MEMaluResult, 32'h10);
        chk("cap_wreg", {31'd0, MEMwreg}, 32'd1);

        // word store / loads
        ex(0, 0, 1, 2'b10, 0, 5'd0, 32'h20, 32'hDEAD_BEEF);
        tick();
        ex(1, 1, 0, 2'b10, 0, 5'd3, 32'h20, 32'h0);
        tick();
        chk("ldw_20", MEMmemOut, 32'hDEAD_BEEF);
        chk("ldw_m2r", {31'd0, MEMm2reg}, 32'd1);
        ex(1, 1, 0, 2'b00, 1, 5'd3, 32'h23, 32'h0);
        tick();
        chk("ldb_23_s", MEMmemOut, 32'hFFFF_FFDE);
        ex(1, 1, 0, 2'b00, 0, 5'd3, 32'h23, 32'h0);
        tick();
        chk("ldb_23_z", MEMmemOut, 32'h0000_00DE);
        ex(1, 1, 0, 2'b01, 1, 5'd3, 32'h22, 32'h0);
        tick();
        chk("ldh_22_s", MEMmemOut, 32'hFFFF_DEAD);

        // byte then half store
        ex(0, 0, 1, 2'b00, 0, 5'd0, 32'h21, 32'hFFFF_FF5A);
        tick();
        ex(1, 1, 0, 2'b10, 0, 5'd4, 32'h20, 32'h0);
        tick();
        chk("st_byte", MEMmemOut, 32'hDEAD_5AEF);
        ex(0, 0, 1, 2'b01, 0, 5'd0, 32'h22, 32'hABCD_1234);
        tick();
        ex(1, 1, 0, 2'b10, 0, 5'd4, 32'h20, 32'h0);
        tick();
        chk("st_half", MEMmemOut, 32'h1234_5AEF);
        ex(1, 1, 0, 2'b00, 1, 5'd4, 32'h21, 32'h0);
        tick();
        chk("ldb_21_s", MEMmemOut, 32'h0000_005A);

        // stall holds a store and commits it once
        ex(0, 0, 1, 2'b10, 0, 5'd0, 32'h40, 32'hCAFE_F00D);
        tick();
        ex(1, 0, 1, 2'b10, 0, 5'd9, 32'h40, 32'h1111_1111);
        tick();
        chk("pre_stall", MEMmemOut, 32'hCAFE_F00D);
        stall = 1'b1;
        ex(0, 1, 1, 2'b00, 0, 5'd2, 32'h80, 32'h2222_2222);
        tick();
        chk("stall1_alu", MEMaluResult, 32'h40);
        chk("stall1_mem", MEMmemOut, 32'hCAFE_F00D);
        EXdi = 32'h3333_3333;
        tick();
        chk("stall2_wn", {27'd0, MEMwn}, 32'd9);
        chk("stall2_mem", MEMmemOut, 32'hCAFE_F00D);
        EXdi = 32'h4444_4444;
        tick();
        chk("stall3_wreg", {31'd0, MEMwreg}, 32'd1);
        chk("stall3_m2r", {31'd0, MEMm2reg}, 32'd0);
        chk("stall3_mem", MEMmemOut, 32'hCAFE_F00D);
        stall = 1'b0;
        ex(1, 1, 0, 2'b10, 0, 5'd6, 32'h40, 32'h0);
        tick();
        chk("post_stall", MEMmemOut, 32'h1111_1111);

        // flushed store never writes
        flush = 1'b1;
        ex(1, 1, 1, 2'b10, 0, 5'd8, 32'h40, 32'h9999_9999);
        tick();
        chk("flush_wreg", {31'd0, MEMwreg}, 32'd0);
        chk("flush_m2r", {31'd0, MEMm2reg}, 32'd0);
        flush = 1'b0;
        ex(1, 1, 0, 2'b10, 0, 5'd6, 32'h40, 32'h0);
        tick();
        chk("flush_mem", MEMmemOut, 32'h1111_1111);
        tick();
        chk("flush_mem2", MEMmemOut, 32'h1111_1111);

        // address wrap: 0x1020 aliases 0x020
        ex(0, 0, 1, 2'b10, 0, 5'd0, 32'h1020, 32'h0BAD_CAFE);
        tick();
        ex(1, 1, 0, 2'b10, 0, 5'd1, 32'h20, 32'h0);
        tick();
        chk("alias", MEMmemOut, 32'h0BAD_CAFE);

        // misaligned word store at 0x22
        ex(0, 0, 1, 2'b10, 0, 5'd0, 32'h22, 32'h7766_5544);
        tick();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_flag", {31'd0, MEMmisalign}, 32'd1);
`else
        chk("mis_flag", {31'd0, MEMmisalign}, 32'd0);
`endif
        ex(1, 1, 0, 2'b10, 0, 5'd1, 32'h20, 32'h0);
        tick();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_store", MEMmemOut, 32'h0BAD_CAFE);
`else
        chk("mis_store", MEMmemOut, 32'h5544_CAFE);
`endif
        ex(1, 1, 0, 2'b10, 0, 5'd1, 32'h22, 32'h0);
        tick();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_load", MEMmemOut, 32'h0000_0000);
`else
        chk("mis_load", MEMmemOut, 32'h0000_5544);
`endif

        // dword size on 32-bit acts as word
        ex(1, 1, 0, 2'b11, 0, 5'd1, 32'h40, 32'h0);
        tick();
        chk("size11", MEMmemOut, 32'h1111_1111);

        // clr during a pending store blocks the commit
        ex(0, 0, 1, 2'b10, 0, 5'd0, 32'h40, 32'h5555_5555);
        tick();
        clr = 1'b1;
        ex(0, 0, 0, 2'b10, 0, 5'd0, 32'h0, 32'h0);
        tick();
        clr = 1'b0;
        ex(1, 1, 0, 2'b10, 0, 5'd1, 32'h40, 32'h0);
        tick();
        chk("clr_nowr", MEMmemOut, 32'h1111_1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
